// File: rtl/control_conjunto_reg_pkg.sv
// Shared sizes and encodings for the register-file write-port sequencer.
package control_conjunto_reg_pkg;
   localparam int NUM_REGS   = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int DATA_WIDTH = 32;

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic GRANT_A = 1'b0;
   localparam logic GRANT_B = 1'b1;
endpackage

// File: rtl/control_conjunto_reg_arbitro_rr2.sv
// Two-way round-robin arbiter; a grant is only issued while active.
module arbitro_rr2
   import control_conjunto_reg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);
   logic last_grant;

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (active) begin
         if (req_a && req_b) begin
            // Contention: whoever did not win last time goes first.
            gnt_a = (last_grant == GRANT_B);
            gnt_b = (last_grant == GRANT_A);
         end else begin
            gnt_a = req_a;
            gnt_b = req_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= GRANT_B;
      else if (gnt_a)
         last_grant <= GRANT_A;
      else if (gnt_b)
         last_grant <= GRANT_B;
   end
endmodule

// File: rtl/control_conjunto_reg.sv
// Zeroes the register file after reset, then arbitrates its write port
// between two requesters and forwards the pending write onto the read ports.
module control_conjunto_reg
   import control_conjunto_reg_pkg::*;
#(
   parameter int NUM_REGS_P   = NUM_REGS,
   parameter int ADDR_WIDTH_P = ADDR_WIDTH,
   parameter int DATA_WIDTH_P = DATA_WIDTH
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wa_valid,
   output logic                    wa_ready,
   input  logic [ADDR_WIDTH_P-1:0] wa_addr,
   input  logic [DATA_WIDTH_P-1:0] wa_data,
   input  logic                    wb_valid,
   output logic                    wb_ready,
   input  logic [ADDR_WIDTH_P-1:0] wb_addr,
   input  logic [DATA_WIDTH_P-1:0] wb_data,
   input  logic [ADDR_WIDTH_P-1:0] rs1_addr,
   input  logic [ADDR_WIDTH_P-1:0] rs2_addr,
   output logic [DATA_WIDTH_P-1:0] rs1_data,
   output logic [DATA_WIDTH_P-1:0] rs2_data,
   output logic                    init_done,
   output logic                    rf_write_enable,
   output logic [ADDR_WIDTH_P-1:0] rf_write_addr,
   output logic [DATA_WIDTH_P-1:0] rf_write_data,
   output logic [ADDR_WIDTH_P-1:0] rf_addr1,
   output logic [ADDR_WIDTH_P-1:0] rf_addr2,
   input  logic [DATA_WIDTH_P-1:0] rf_data1,
   input  logic [DATA_WIDTH_P-1:0] rf_data2
);
   localparam logic [ADDR_WIDTH_P-1:0] LAST_REG = ADDR_WIDTH_P'(NUM_REGS_P - 1);

   logic                    state;
   logic [ADDR_WIDTH_P-1:0] init_cnt;
   logic                    accept;
   logic [ADDR_WIDTH_P-1:0] win_addr;
   logic [DATA_WIDTH_P-1:0] win_data;

   arbitro_rr2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .active (state == ST_RUN),
      .req_a  (wa_valid),
      .req_b  (wb_valid),
      .gnt_a  (wa_ready),
      .gnt_b  (wb_ready)
   );

   // A grant implies the matching valid, so either ready marks a handshake.
   assign accept   = wa_ready | wb_ready;
   assign win_addr = wa_ready ? wa_addr : wb_addr;
   assign win_data = wa_ready ? wa_data : wb_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_INIT;
         init_cnt        <= ADDR_WIDTH_P'(1);
         init_done       <= 1'b0;
         rf_write_enable <= 1'b0;
         rf_write_addr   <= '0;
         rf_write_data   <= '0;
      end else if (state == ST_INIT) begin
         rf_write_enable <= 1'b1;
         rf_write_addr   <= init_cnt;
         rf_write_data   <= '0;
         if (init_cnt == LAST_REG) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
         end else begin
            init_cnt <= init_cnt + ADDR_WIDTH_P'(1);
         end
      end else if (accept) begin
         // x0 writes complete the handshake but never reach the file.
         rf_write_enable <= (win_addr != '0);
         rf_write_addr   <= win_addr;
         rf_write_data   <= win_data;
      end else begin
         rf_write_enable <= 1'b0;
      end
   end

   assign rf_addr1 = rs1_addr;
   assign rf_addr2 = rs2_addr;

   assign rs1_data = (!init_done || rs1_addr == '0) ? '0 :
                     (rf_write_enable && rf_write_addr == rs1_addr) ? rf_write_data : rf_data1;
   assign rs2_data = (!init_done || rs2_addr == '0) ? '0 :
                     (rf_write_enable && rf_write_addr == rs2_addr) ? rf_write_data : rf_data2;
endmodule

// File: tb/tb_control_conjunto_reg.sv
// Randomized scoreboard bench: an architectural register model predicts
// reads and grants; a monitor checks every write reaching the register file.
module tb_control_conjunto_reg;
   logic        clk = 1'b0;
   logic        rst;
   logic        wa_valid, wb_valid;
   logic        wa_ready, wb_ready;
   logic [4:0]  wa_addr, wb_addr, rs1_addr, rs2_addr;
   logic [31:0] wa_data, wb_data, rs1_data, rs2_data;
   logic        init_done;
   logic        rf_write_enable;
   logic [4:0]  rf_write_addr, rf_addr1, rf_addr2;
   logic [31:0] rf_write_data, rf_data1, rf_data2;

   control_conjunto_reg dut (
      .clk(clk), .rst(rst),
      .wa_valid(wa_valid), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .init_done(init_done), .rf_write_enable(rf_write_enable),
      .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2)
   );

   always #5 clk = ~clk;

   // Register file without reset, as seen by the design.
   logic [31:0] regs [32];
   always @(posedge clk) if (rf_write_enable) regs[rf_write_addr] <= rf_write_data;
   assign rf_data1 = regs[rf_addr1];
   assign rf_data2 = regs[rf_addr2];

   typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
   wr_t wq[$];

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Every enabled write must match the next expected one, in order.
   always @(negedge clk) begin
      if (rf_write_enable === 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexpected_write_addr", 32'(rf_write_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk("write_addr", 32'(rf_write_addr), 32'(w.a));
            chk("write_data", rf_write_data, w.d);
         end
      end
   end

   // Architectural model
   logic [31:0] arch [32];
   bit          m_run;
   bit          m_last_b;
   int          m_sweep;

   function automatic logic [31:0] exp_read(input logic [4:0] a);
      return (!m_run || a == 0) ? 32'h0 : arch[a];
   endfunction

   task automatic step(input logic r,
                       input logic va, input logic [4:0] aa, input logic [31:0] da,
                       input logic vb, input logic [4:0] ab, input logic [31:0] db,
                       input logic [4:0] r1, input logic [4:0] r2);
      logic ga, gb;
      wr_t  w;
      rst = r; wa_valid = va; wa_addr = aa; wa_data = da;
      wb_valid = vb; wb_addr = ab; wb_data = db; rs1_addr = r1; rs2_addr = r2;
      @(negedge clk);
      ga = 1'b0; gb = 1'b0;
      if (m_run) begin
         if (va && vb) begin ga = m_last_b; gb = !m_last_b; end
         else begin ga = va; gb = vb; end
      end
      if (!r) begin
         chk("wa_ready", 32'(wa_ready), 32'(ga));
         chk("wb_ready", 32'(wb_ready), 32'(gb));
      end
      chk("init_done", 32'(init_done), 32'(m_run));
      chk("rs1_data", rs1_data, exp_read(r1));
      chk("rs2_data", rs2_data, exp_read(r2));
      @(posedge clk);
      if (r) begin
         m_run = 0; m_last_b = 1; m_sweep = 0;
      end else if (!m_run) begin
         m_sweep++;
         w.a = 5'(m_sweep); w.d = 32'h0;
         wq.push_back(w);
         if (m_sweep == 31) begin
            m_run = 1;
            for (int i = 0; i < 32; i++) arch[i] = 32'h0;
         end
      end else if (ga || gb) begin
         w.a = ga ? aa : ab;
         w.d = ga ? da : db;
         if (w.a != 0) begin
            wq.push_back(w);
            arch[w.a] = w.d;
         end
         m_last_b = gb;
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, r1, r2);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      for (int i = 0; i < 32; i++) arch[i] = 32'h0;
      rst = 1'b1; wa_valid = 0; wb_valid = 0; wa_addr = 0; wb_addr = 0;
      wa_data = 0; wb_data = 0; rs1_addr = 5; rs2_addr = 0;
      m_run = 0; m_last_b = 1; m_sweep = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_we", 32'(rf_write_enable), 32'h0);
      chk("rst_waddr", 32'(rf_write_addr), 32'h0);
      chk("rst_wdata", rf_write_data, 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      @(posedge clk); #1;

      // Sweep, with x5 observed the whole time and requesters idle.
      repeat (35) idle(5'd5, 5'($urandom_range(0, 31)));
      step(1'b0, 1'b1, 5'd1, 32'h5041544F, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
      idle(5'd1, 5'd1);
      idle(5'd1, 5'd0);
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd1, 5'd0);
      idle(5'd0, 5'd0);
      repeat (4) step(1'b0, 1'b1, 5'd2, 32'hA, 1'b1, 5'd3, 32'hB, 5'd2, 5'd3);
      idle(5'd2, 5'd3);
      step(1'b0, 1'b1, 5'd4, 32'h11, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
      step(1'b0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4);
      idle(5'd4, 5'd4);
      idle(5'd4, 5'd4);

      // Small address range to provoke collisions and forwarding.
      repeat (300)
         step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

      // Reset mid-run with A requesting: nothing may be written, sweep restarts.
      idle(5'd1, 5'd2);
      step(1'b1, 1'b1, 5'd1, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
      repeat (34) idle(5'd1, 5'd4);
      repeat (20)
         step(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      idle(5'd0, 5'd0);
      @(negedge clk); #1;
      chk("pending_writes_left", 32'(wq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
